// File: rtl/instruction_loader.sv
// Byte-serial program loader and fetch stage feeding a 14-bit instruction word to the CPU.
// Optional download checksum output is enabled by defining ILOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [7:0]        pc,
  output logic [13:0]       instruction,
  output logic              running,
  output logic              prog_full,
  output logic [ADDR_W:0]   load_count
`ifdef ILOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StLoadHi,
    StLoadLo,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic              full_q, full_d;
  logic [13:0]       instr_q, instr_d;
  logic              ready_q, ready_d;
  logic              running_q, running_d;

  logic [13:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [13:0]       mem_wdata;

  logic              xfer;
  logic [5:0]        idx;
  logic              hit;
  logic              start_load;

  // pc advances by 4 and the low bits of the second byte carry no opcode data.
  logic              unused_bits;
  assign unused_bits = ^{pc[1:0], byte_in[1:0]};

  assign xfer = byte_valid && ready_q;
  assign idx  = pc[7:2];
  assign hit  = (7'(idx) < 7'(count_q));

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    hi_d       = hi_q;
    full_d     = full_q;
    mem_we     = 1'b0;
    mem_wdata  = {hi_q, byte_in[7:2]};
    start_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_mode) begin
          start_load = 1'b1;
        end else if (count_q != '0) begin
          state_d = StRun;
        end
      end
      StLoadHi: begin
        if (xfer) begin
          hi_d    = byte_in;
          state_d = load_mode ? StLoadLo : StIdle;
        end else if (!load_mode) begin
          state_d = StIdle;
        end
      end
      StLoadLo: begin
        if (xfer) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          if (wptr_q == ADDR_W'(DEPTH - 1)) begin
            full_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = load_mode ? StLoadHi : StIdle;
          end
        end else if (!load_mode) begin
          // Partial word is dropped; the hi byte never reaches memory.
          state_d = StIdle;
        end
      end
      StRun: begin
        if (load_mode) begin
          start_load = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start_load) begin
      state_d = StLoadHi;
      wptr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end
  end

  always_comb begin
    ready_d   = (state_d == StLoadHi) || (state_d == StLoadLo);
    running_d = (state_d == StRun);
    instr_d   = '0;
    if ((state_d == StRun) && hit) begin
      instr_d = mem_q[idx[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      full_q    <= 1'b0;
      instr_q   <= '0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      full_q    <= full_d;
      instr_q   <= instr_d;
      ready_q   <= ready_d;
      running_q <= running_d;
    end
  end

  // Storage is not reset; load_count alone defines which words are valid.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wptr_q] <= mem_wdata;
    end
  end

`ifdef ILOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (start_load) begin
      chk_d = '0;
    end else if (xfer) begin
      chk_d = chk_q ^ byte_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`endif

  assign byte_ready  = ready_q;
  assign instruction = instr_q;
  assign running     = running_q;
  assign prog_full   = full_q;
  assign load_count  = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: load, fetch, partial word, full program and async reset.
// Checksum checks are compiled in when ILOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

  logic        clock;
  logic        reset;
  logic        load_mode;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  pc;
  logic [13:0] instruction;
  logic        running;
  logic        prog_full;
  logic [4:0]  load_count;
`ifdef ILOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;

  instruction_loader #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_mode  (load_mode),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pc         (pc),
    .instruction(instruction),
    .running    (running),
    .prog_full  (prog_full),
    .load_count (load_count)
`ifdef ILOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_mode  = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    pc         = 8'h00;
    @(negedge clock);
    @(negedge clock);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_ready", 32'(byte_ready), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_full", 32'(prog_full), 32'h0);
    check("rst_count", 32'(load_count), 32'h0);
`ifdef ILOADER_CHECKSUM_EN
    check("rst_chk", 32'(checksum), 32'h0);
`endif

    reset = 1'b0;
    tick();
    tick();
    check("idle_empty_running", 32'(running), 32'h0);
    check("idle_ready", 32'(byte_ready), 32'h0);

    // First word: 0xAB, 0xCD -> 14'h2AF3
    load_mode = 1'b1;
    tick();
    check("loadhi_ready", 32'(byte_ready), 32'h1);
    byte_valid = 1'b1;
    byte_in    = 8'hAB;
    tick();
    check("loadlo_ready", 32'(byte_ready), 32'h1);
    check("loadlo_count", 32'(load_count), 32'h0);
    byte_in = 8'hCD;
    tick();
    check("word0_count", 32'(load_count), 32'h1);
    byte_in = 8'h12;
    tick();
    byte_in = 8'h34;
    tick();
    byte_in = 8'hFF;
    tick();
    byte_in = 8'hFF;
    tick();
    check("three_count", 32'(load_count), 32'h3);
    byte_valid = 1'b0;
    load_mode  = 1'b0;
    pc         = 8'd0;
    tick();
    check("to_idle_ready", 32'(byte_ready), 32'h0);
    check("to_idle_running", 32'(running), 32'h0);
    check("to_idle_instr", 32'(instruction), 32'h0);
    tick();
    check("run_running", 32'(running), 32'h1);
    check("run_pc0", 32'(instruction), 32'h2AF3);
    pc = 8'd4;
    tick();
    check("run_pc4", 32'(instruction), 32'h048D);
    pc = 8'd8;
    tick();
    check("run_pc8", 32'(instruction), 32'h3FFF);
    pc = 8'd12;
    tick();
    check("run_pc12_oob", 32'(instruction), 32'h0);
    pc = 8'd5;
    tick();
    check("run_pc5", 32'(instruction), 32'h048D);
    pc = 8'd255;
    tick();
    check("run_pc255_oob", 32'(instruction), 32'h0);

    // Reload one word, then a lone hi byte that must be discarded.
    load_mode = 1'b1;
    tick();
    check("reload_instr", 32'(instruction), 32'h0);
    check("reload_count", 32'(load_count), 32'h0);
    check("reload_running", 32'(running), 32'h0);
    check("reload_ready", 32'(byte_ready), 32'h1);
`ifdef ILOADER_CHECKSUM_EN
    check("reload_chk_clr", 32'(checksum), 32'h0);
`endif
    byte_valid = 1'b1;
    byte_in    = 8'hAB;
    tick();
    byte_in = 8'hCD;
    tick();
    byte_in = 8'h12;
    tick();
    byte_valid = 1'b0;
    load_mode  = 1'b0;
    pc         = 8'd4;
    tick();
    check("partial_count", 32'(load_count), 32'h1);
    check("partial_ready", 32'(byte_ready), 32'h0);
`ifdef ILOADER_CHECKSUM_EN
    check("partial_chk", 32'(checksum), 32'h74);
`endif
    tick();
    check("partial_run_pc4", 32'(instruction), 32'h0);
    pc = 8'd0;
    tick();
    check("partial_run_pc0", 32'(instruction), 32'h2AF3);

    // Full program: byte i for i = 0..31, valid held high.
    load_mode = 1'b1;
    pc        = 8'd60;
    tick();
    byte_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      byte_in = 8'(i);
      tick();
    end
    check("full_flag", 32'(prog_full), 32'h1);
    check("full_count", 32'(load_count), 32'h10);
    check("full_ready", 32'(byte_ready), 32'h0);
    check("full_running", 32'(running), 32'h0);
    byte_valid = 1'b0;
    load_mode  = 1'b0;
    tick();
    check("full_run_pc60", 32'(instruction), 32'h0787);
    pc = 8'd28;
    tick();
    check("full_run_pc28", 32'(instruction), 32'h0383);
    check("full_run_flag", 32'(prog_full), 32'h1);

    // Asynchronous reset during RUN.
    reset = 1'b1;
    #1;
    check("rstrun_instr", 32'(instruction), 32'h0);
    check("rstrun_count", 32'(load_count), 32'h0);
    check("rstrun_running", 32'(running), 32'h0);
    check("rstrun_full", 32'(prog_full), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    check("rstrun_stay_idle", 32'(running), 32'h0);

    // Asynchronous reset during LOAD_LO with one word already stored.
    load_mode = 1'b1;
    tick();
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    tick();
    byte_in = 8'h66;
    tick();
    byte_in = 8'h77;
    tick();
    check("pre_rstlo_count", 32'(load_count), 32'h1);
    reset = 1'b1;
    #1;
    check("rstlo_count", 32'(load_count), 32'h0);
    check("rstlo_ready", 32'(byte_ready), 32'h0);
    check("rstlo_instr", 32'(instruction), 32'h0);
    @(negedge clock);
    reset      = 1'b0;
    load_mode  = 1'b0;
    byte_valid = 1'b0;
    tick();
    tick();
    check("rstlo_stay_idle", 32'(running), 32'h0);
    check("rstlo_idle_count", 32'(load_count), 32'h0);

`ifdef ILOADER_CHECKSUM_EN
    load_mode = 1'b1;
    tick();
    byte_valid = 1'b1;
    byte_in    = 8'h01;
    tick();
    byte_in = 8'h02;
    tick();
    byte_in = 8'h04;
    tick();
    byte_in = 8'h08;
    tick();
    byte_valid = 1'b0;
    check("chk_0f", 32'(checksum), 32'h0F);
    load_mode = 1'b0;
    tick();
    load_mode = 1'b1;
    tick();
    check("chk_reentry_clr", 32'(checksum), 32'h0);
    load_mode = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
